// File: rtl/program_memory.sv
// Program memory with a boot sequencer: zero every word, accept a loader stream at
// LOAD_BASE, then release the CPU and serve single-port registered reads and writes.
module program_memory #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LOAD_BASE  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] out,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  cpu_rst_n,
   output logic [ADDR_WIDTH:0]   load_count
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_LOAD,
      ST_RUN
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [ADDR_WIDTH-1:0]   clr_cnt_next;
   logic [ADDR_WIDTH-1:0]   ptr;
   logic [ADDR_WIDTH-1:0]   ptr_next;
   logic [CNT_W-1:0]        cnt_next;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Next-state logic; the single memory write port is shared by clear, loader and CPU.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      ptr_next     = ptr;
      cnt_next     = load_count;
      mem_we       = 1'b0;
      mem_addr     = addr;
      mem_wdata    = data;
      case (state)
         ST_CLEAR: begin
            mem_we       = 1'b1;
            mem_addr     = clr_cnt;
            mem_wdata    = '0;
            clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == LAST_ADDR) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_addr  = ptr;
               mem_wdata = ld_data;
               cnt_next  = load_count + CNT_W'(1);
               // The top word ends the load regardless of ld_last; the pointer never wraps.
               if (ld_last || (ptr == LAST_ADDR)) state_next = ST_RUN;
               if (ptr != LAST_ADDR) ptr_next = ptr + ADDR_WIDTH'(1);
            end
         end
         ST_RUN: begin
            mem_we = we;
         end
         default: begin
            state_next = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         ptr        <= BASE_ADDR;
         load_count <= '0;
         out        <= '0;
         ld_ready   <= 1'b0;
         cpu_rst_n  <= 1'b0;
      end else begin
         state      <= state_next;
         clr_cnt    <= clr_cnt_next;
         ptr        <= ptr_next;
         load_count <= cnt_next;
         out        <= (state == ST_RUN) ? mem[addr] : '0;
         ld_ready   <= (state_next == ST_LOAD);
         cpu_rst_n  <= (state_next == ST_RUN);
      end
   end

   // Storage array is not reset; the CLEAR phase zeroes it.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

endmodule

// File: tb/tb_program_memory.sv
// Randomized bench for program_memory against a phase-level reference model of
// the clear/load/run boot sequence and the memory contents.
module tb_program_memory;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [5:0]  addr;
   logic [15:0] data;
   logic [15:0] out;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        cpu_rst_n;
   logic [6:0]  load_count;

   program_memory dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (we),
      .addr       (addr),
      .data       (data),
      .out        (out),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .cpu_rst_n  (cpu_rst_n),
      .load_count (load_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0 = clearing, 1 = loading, 2 = running.
   int unsigned m_mem [64];
   int          m_phase;
   int          m_clr;
   int          m_ptr;
   int          m_cnt;
   int unsigned m_out;

   int n_cmp;
   int n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out",        32'(out),        m_out);
      chk("ld_ready",   32'(ld_ready),   32'(m_phase == 1));
      chk("cpu_rst_n",  32'(cpu_rst_n),  32'(m_phase == 2));
      chk("load_count", 32'(load_count), 32'(m_cnt));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic step(input logic v, input logic [15:0] d, input logic l,
                       input logic w, input logic [5:0] a, input logic [15:0] wd);
      ld_valid = v;
      ld_data  = d;
      ld_last  = l;
      we       = w;
      addr     = a;
      data     = wd;
      @(posedge clk);
      m_out = 0;
      case (m_phase)
         0: begin
            m_mem[m_clr] = 0;
            m_clr++;
            if (m_clr == 64) m_phase = 1;
         end
         1: if (v) begin
            m_mem[m_ptr] = 32'(d);
            m_cnt++;
            if (l || m_ptr == 63) m_phase = 2;
            else m_ptr++;
         end
         default: begin
            m_out = m_mem[a];
            if (w) m_mem[a] = 32'(wd);
         end
      endcase
      #1;
      check_outputs();
   endtask

   task automatic rnd_step();
      step(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom));
   endtask

   task automatic idle_load(input int n);
      repeat (n) step(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 16'($urandom));
   endtask

   task automatic read_at(input logic [5:0] a);
      step(1'b0, 16'h0, 1'b0, 1'b0, a, 16'h0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      m_phase = 0;
      m_clr   = 0;
      m_ptr   = 8;
      m_cnt   = 0;
      m_out   = 0;
      check_outputs();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b1;
      we       = 1'b0;
      addr     = '0;
      data     = '0;
      ld_valid = 1'b0;
      ld_data  = '0;
      ld_last  = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 0;

      // Scenario 1: clear with junk on every input, short directed load, directed run.
      #2 apply_reset();
      repeat (64) rnd_step();
      idle_load(3);
      step(1'b1, 16'h7100, 1'b0, 1'b1, 6'd3, 16'h1111);
      idle_load(1);
      step(1'b1, 16'h8100, 1'b0, 1'b0, 6'd0, 16'h0);
      step(1'b1, 16'hF000, 1'b1, 1'b1, 6'd4, 16'h2222);
      read_at(6'd8);
      read_at(6'd9);
      read_at(6'd10);
      read_at(6'd11);
      step(1'b1, 16'hAAAA, 1'b1, 1'b1, 6'd3, 16'hBEEF);
      read_at(6'd3);
      repeat (80) rnd_step();

      // Scenario 2: reset mid-run, stream 56 words with gaps, no ld_last.
      #3 apply_reset();
      repeat (64) rnd_step();
      for (int i = 0; i < 56; i++) begin
         idle_load(int'($urandom_range(0, 2)));
         step(1'b1, 16'($urandom), 1'b0, 1'($urandom), 6'($urandom), 16'($urandom));
      end
      for (int a = 0; a < 64; a++) read_at(6'(a));
      repeat (40) rnd_step();

      // Scenario 3: reset mid-run, abort a load mid-word, reload one word.
      #3 apply_reset();
      repeat (64) rnd_step();
      step(1'b1, 16'h1234, 1'b0, 1'b0, 6'd0, 16'h0);
      step(1'b1, 16'h5678, 1'b0, 1'b0, 6'd0, 16'h0);
      ld_valid = 1'b1;
      ld_data  = 16'h5555;
      #3 apply_reset();
      repeat (64) rnd_step();
      idle_load(2);
      step(1'b1, 16'h0ABC, 1'b1, 1'b0, 6'd0, 16'h0);
      for (int a = 0; a < 64; a++) read_at(6'(a));
      repeat (60) rnd_step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
